// File: rtl/core_seq_ctrl.sv
// Multi-cycle NPC core sequencer: owns the PC, fetches, then steps decode/exec/write-back.
// Latency: at least 4 cycles per instruction (FETCH, DECODE, EXEC, WB), plus fetch wait and exu busy cycles.
// Backpressure: waits in FETCH for imem_rvalid (fault after IMEM_TIMEOUT cycles) and in EXEC while ex_busy.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   imem_req/addr       fetch request (held through FETCH) and address (= pc)
//   imem_rvalid/rdata   fetch response; a same-cycle response is accepted
//   inst_q              latched instruction word for the decoder
//   dec_en              high in DECODE; reg_wr_in/illegal_in/halt_in sampled then
//   ex_en               high in EXEC; ex_busy holds it, pc_next_in sampled when not busy
//   rf_wen              one-cycle register write pulse in WB
//   pc, instret         current PC and retired instruction count
//   halted, fault       sticky terminal status (ebreak / error)
module core_seq_ctrl #(
  parameter logic [63:0] RESET_PC     = 64'h8000_0000,
  parameter int unsigned IMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_q,
  output logic        dec_en,
  input  logic        reg_wr_in,
  input  logic        illegal_in,
  input  logic        halt_in,
  output logic        ex_en,
  input  logic        ex_busy,
  input  logic [63:0] pc_next_in,
  output logic        rf_wen,
  output logic [63:0] pc,
  output logic [63:0] instret,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  // Last fetch_cnt value tolerated without a response; the FETCH cycle that
  // sees this count with no rvalid is the IMEM_TIMEOUT-th one.
  localparam logic [7:0] FETCH_LAST = 8'(IMEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] npc_q, npc_d;
  logic [31:0] inst_d;
  logic [63:0] instret_q, instret_d;
  logic [7:0]  fetch_cnt_q, fetch_cnt_d;
  logic        wr_q, wr_d;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      npc_q       <= RESET_PC;
      inst_q      <= 32'd0;
      instret_q   <= 64'd0;
      fetch_cnt_q <= 8'd0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      npc_q       <= npc_d;
      inst_q      <= inst_d;
      instret_q   <= instret_d;
      fetch_cnt_q <= fetch_cnt_d;
      wr_q        <= wr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    npc_d       = npc_q;
    inst_d      = inst_q;
    instret_d   = instret_q;
    fetch_cnt_d = fetch_cnt_q;
    wr_d        = wr_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (imem_rvalid) begin
          inst_d      = imem_rdata;
          fetch_cnt_d = 8'd0;
          state_d     = S_DECODE;
        end else if (fetch_cnt_q == FETCH_LAST) begin
          fetch_cnt_d = 8'd0;
          state_d     = S_ERR;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 8'd1;
        end
      end

      S_DECODE: begin
        // Illegal wins over ebreak; a halting ebreak never retires.
        if (illegal_in) begin
          state_d = S_ERR;
        end else if (halt_in) begin
          state_d = S_HALT;
        end else begin
          wr_d    = reg_wr_in;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (!ex_busy) begin
          // A misaligned target faults before write-back so the register
          // file and pc are left untouched.
          if (pc_next_in[1:0] != 2'b00) begin
            state_d = S_ERR;
          end else begin
            npc_d   = pc_next_in;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        pc_d      = npc_q;
        instret_d = instret_q + 64'd1;
        state_d   = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        // Unreachable encoding: treat as a fault rather than wander.
        state_d = S_ERR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, no input-to-output paths
  // ---------------------------------------------------------------------------
  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign dec_en    = (state_q == S_DECODE);
  assign ex_en     = (state_q == S_EXEC);
  assign rf_wen    = (state_q == S_WB) && wr_q;
  assign pc        = pc_q;
  assign instret   = instret_q;
  assign halted    = (state_q == S_HALT);
  assign fault     = (state_q == S_ERR);

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] INST   = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst_q;
  logic        dec_en;
  logic        reg_wr_in;
  logic        illegal_in;
  logic        halt_in;
  logic        ex_en;
  logic        ex_busy;
  logic [63:0] pc_next_in;
  logic        rf_wen;
  logic [63:0] pc;
  logic [63:0] instret;
  logic        halted;
  logic        fault;

  always #5 clk = ~clk;

  core_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_q     (inst_q),
    .dec_en     (dec_en),
    .reg_wr_in  (reg_wr_in),
    .illegal_in (illegal_in),
    .halt_in    (halt_in),
    .ex_en      (ex_en),
    .ex_busy    (ex_busy),
    .pc_next_in (pc_next_in),
    .rf_wen     (rf_wen),
    .pc         (pc),
    .instret    (instret),
    .halted     (halted),
    .fault      (fault)
  );

  // Environment configuration, set per test while reset is held.
  logic        rv_tied = 1'b0;
  int          rv_delay = 0;
  int          busy_cycles = 0;
  int          halt_at = 99;
  int          ill_at = 99;
  logic [7:0]  wr_mask = 8'hFF;
  logic        bad_pc_en = 1'b0;
  logic        bad_while_busy = 1'b0;
  logic [63:0] bad_pc = 64'h8000_0002;

  // Environment state counters.
  int req_cnt, ex_cnt, dec_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt <= 0;
      ex_cnt  <= 0;
      dec_idx <= 0;
    end else begin
      req_cnt <= (imem_req && !imem_rvalid) ? req_cnt + 1 : 0;
      ex_cnt  <= ex_en ? ex_cnt + 1 : 0;
      if (dec_en) dec_idx <= dec_idx + 1;
    end
  end

  assign imem_rvalid = rv_tied || (imem_req && (req_cnt >= rv_delay));
  assign imem_rdata  = INST;
  assign ex_busy     = ex_en && (ex_cnt < busy_cycles);
  assign illegal_in  = dec_en && (dec_idx == ill_at);
  assign halt_in     = dec_en && (dec_idx == halt_at);
  assign reg_wr_in   = dec_en && wr_mask[dec_idx[2:0]];
  assign pc_next_in  = ((bad_while_busy && ex_busy) || bad_pc_en) ? bad_pc : pc + 64'd4;

  // Scoreboard.
  int errors = 0;
  int checks = 0;
  logic [63:0]  exp_fetch_q[$];
  logic [127:0] exp_wb_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT completes a fetch handshake
  // or pulses the register write enable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_rvalid) begin
        if (exp_fetch_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fetch: got addr %0h expected no fetch", imem_addr);
        end else begin
          chk("fetch_addr", imem_addr, exp_fetch_q.pop_front());
        end
      end
      if (rf_wen) begin
        chk("wb_exclusive", {dec_en, ex_en, imem_req, halted, fault}, 0);
        if (exp_wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: got rf_wen at pc %0h expected no write", pc);
        end else begin
          chk("wb_pc_instret", {pc, instret}, exp_wb_q.pop_front());
        end
      end
    end
  end

  // Observations collected by run().
  int n_req, n_ex, n_wen, first_wen, first_dec, last_req, stop_cyc;
  logic addr_moved;
  logic [63:0] prev_addr;

  // Runs from the reset-release negedge (cycle 0) until halted/fault.
  task automatic run(input int max);
    n_req = 0; n_ex = 0; n_wen = 0; first_wen = -1; first_dec = -1;
    last_req = -1; stop_cyc = -1; addr_moved = 1'b0; prev_addr = '0;
    for (int c = 0; c < max; c++) begin
      if (imem_req) begin
        if (last_req == c - 1 && n_req > 0 && imem_addr !== prev_addr) addr_moved = 1'b1;
        prev_addr = imem_addr;
        n_req++;
        last_req = c;
      end
      if (ex_en) n_ex++;
      if (rf_wen) begin
        n_wen++;
        if (first_wen < 0) first_wen = c;
      end
      if (dec_en && first_dec < 0) first_dec = c;
      if (halted || fault) begin
        stop_cyc = c;
        break;
      end
      @(negedge clk);
    end
    if (stop_cyc < 0) begin
      checks++; errors++;
      $display("FAIL run_timeout: got no halt/fault within %0d cycles expected stop", max);
    end
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rv_tied = 1'b0; rv_delay = 0; busy_cycles = 0; halt_at = 99; ill_at = 99;
    wr_mask = 8'hFF; bad_pc_en = 1'b0; bad_while_busy = 1'b0; bad_pc = 64'h8000_0002;
  endtask

  task automatic queues_empty(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_fetch_q_empty"}, exp_fetch_q.size(), 0);
    chk({tag, "_wb_q_empty"}, exp_wb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    // ---------------- Reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instret", instret, 0);
    chk("rst_inst_q", inst_q, 0);
    chk("rst_enables", {imem_req, dec_en, ex_en, rf_wen}, 0);
    chk("rst_status", {halted, fault}, 0);

    // ---------------- T1: addi, back-to-back, halt on 2nd ----------------
    rv_tied = 1'b1; halt_at = 1;
    exp_fetch_q.push_back(RST_PC);
    exp_fetch_q.push_back(RST_PC + 64'd4);
    exp_wb_q.push_back({RST_PC, 64'd0});
    rst_n = 1'b1;
    chk("t1_cycle0_addr", imem_addr, RST_PC);
    run(50);
    chk("t1_first_wen_cycle", first_wen, 4);
    chk("t1_wen_count", n_wen, 1);
    chk("t1_stop_cycle", stop_cyc, 7);
    chk("t1_status", {halted, fault}, 2'b10);
    chk("t1_pc", pc, RST_PC + 64'd4);
    chk("t1_instret", instret, 1);
    chk("t1_inst_q", inst_q, INST);
    repeat (3) @(negedge clk);
    chk("t4_frozen", {imem_req, dec_en, ex_en, rf_wen, pc, instret}, {4'b0, RST_PC + 64'd4, 64'd1});
    chk("t4_halted_sticky", halted, 1);
    queues_empty("t1");

    // ---------------- T2: rvalid after 3 wait cycles ----------------
    assert_reset();
    rv_delay = 3; halt_at = 0;
    exp_fetch_q.push_back(RST_PC);
    rst_n = 1'b1;
    run(50);
    chk("t2_req_cycles", n_req, 4);
    chk("t2_last_req", last_req, 4);
    chk("t2_first_dec", first_dec, 5);
    chk("t2_addr_stable", addr_moved, 0);
    chk("t2_halt", {halted, fault, pc, instret}, {2'b10, RST_PC, 64'd0});
    queues_empty("t2");

    // ---------------- T3: fetch timeout ----------------
    assert_reset();
    rv_delay = 100000;
    rst_n = 1'b1;
    run(400);
    chk("t3_req_cycles", n_req, 255);
    chk("t3_stop_cycle", stop_cyc, 256);
    chk("t3_status", {halted, fault}, 2'b01);
    chk("t3_no_wen", n_wen, 0);
    @(negedge clk);
    chk("t3_req_low", imem_req, 0);
    queues_empty("t3");

    // ---------------- T5a: illegal beats halt ----------------
    assert_reset();
    ill_at = 0; halt_at = 0;
    exp_fetch_q.push_back(RST_PC);
    rst_n = 1'b1;
    run(50);
    chk("t5a_status", {halted, fault}, 2'b01);
    chk("t5a_stop_cycle", stop_cyc, 3);
    chk("t5a_instret", instret, 0);
    queues_empty("t5a");

    // ---------------- T5b: misaligned next pc ----------------
    assert_reset();
    bad_pc_en = 1'b1;
    exp_fetch_q.push_back(RST_PC);
    rst_n = 1'b1;
    run(50);
    chk("t5b_status", {halted, fault}, 2'b01);
    chk("t5b_stop_cycle", stop_cyc, 4);
    chk("t5b_no_wen", n_wen, 0);
    chk("t5b_pc_instret", {pc, instret}, {RST_PC, 64'd0});
    queues_empty("t5b");

    // ---------------- T6a: exu busy for 5 cycles ----------------
    assert_reset();
    busy_cycles = 5; bad_while_busy = 1'b1; halt_at = 1;
    exp_fetch_q.push_back(RST_PC);
    exp_fetch_q.push_back(RST_PC + 64'd4);
    exp_wb_q.push_back({RST_PC, 64'd0});
    rst_n = 1'b1;
    run(80);
    chk("t6a_ex_cycles", n_ex, 6);
    chk("t6a_first_wen", first_wen, 9);
    chk("t6a_stop_cycle", stop_cyc, 12);
    chk("t6a_status", {halted, fault, pc, instret}, {2'b10, RST_PC + 64'd4, 64'd1});
    queues_empty("t6a");

    // ---------------- T6b: async reset mid-EXEC ----------------
    assert_reset();
    busy_cycles = 100000;
    exp_fetch_q.push_back(RST_PC);
    rst_n = 1'b1;
    begin
      int waited;
      waited = 0;
      while (!ex_en && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      chk("t6b_reached_exec", ex_en, 1);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6b_async_enables", {imem_req, dec_en, ex_en, rf_wen, halted, fault}, 0);
    chk("t6b_async_regs", {pc, instret, inst_q}, {RST_PC, 64'd0, 32'd0});
    @(negedge clk);
    busy_cycles = 0; halt_at = 0;
    exp_fetch_q.push_back(RST_PC);
    rst_n = 1'b1;
    run(50);
    chk("t6b_restart_stop", stop_cyc, 3);
    chk("t6b_restart_req", n_req, 1);
    chk("t6b_restart_status", {halted, fault}, 2'b10);
    queues_empty("t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
